// File: rtl/crack_scheduler.sv
// crack_scheduler
//   Dispatcher for a pool of BCD MD5 crack workers. The 8-digit BCD password
//   space 00000000..END_BCD is cut into chunks of 10^CHUNK_DIGITS passwords.
//   Each idle worker receives one chunk: the scheduler loads its lower and
//   upper bounds and pulses its reset. The first hit stops every worker and
//   latches the password.
//
// Parameters
//   NUM_WORKERS   attached workers (1..16)
//   CHUNK_DIGITS  low BCD digits per chunk (1..7)
//   END_BCD       last password searched, BCD, inclusive
//
// Ports
//   clk, rst_n    clock, synchronous active-low reset
//   start         one-cycle pulse, accepted only when idle or done
//   hash_answer   target hash, sampled on an accepted start
//   wk_hash       registered target hash shared by all workers
//   wk_rst_n      per-worker synchronous active-low reset/restart
//   wk_lower      per-worker lower bound, worker k at [32k +: 32]
//   wk_upper      per-worker upper bound, worker k at [32k +: 32]
//   wk_answer     per-worker answer, worker k at [32k +: 32]
//   wk_found      per-worker answer_found
//   wk_done       per-worker done
//   answer        cracked password, valid when found = 1
//   found         password found
//   done          search finished (found or exhausted)
//   busy          search in progress
//
// Optional build macro
//   CRACK_SCHED_PROGRESS_EN  adds chunks_issued[23:0]: chunks handed out in
//                            the current search, saturating at all ones.
//
// States
//   state   | meaning
//   S_IDLE  | after reset; workers held in reset, waiting for start
//   S_RUN   | handing out chunks, one per cycle at most, watching for hits
//   S_DRAIN | password space exhausted; waiting for assigned workers to finish
//   S_DONE  | result latched, workers held in reset, waiting for start

module crack_scheduler #(
  parameter int          NUM_WORKERS  = 4,
  parameter int          CHUNK_DIGITS = 4,
  parameter logic [31:0] END_BCD      = 32'h99999999
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [127:0]              hash_answer,
  output logic [127:0]              wk_hash,
  output logic [NUM_WORKERS-1:0]    wk_rst_n,
  output logic [32*NUM_WORKERS-1:0] wk_lower,
  output logic [32*NUM_WORKERS-1:0] wk_upper,
  input  logic [32*NUM_WORKERS-1:0] wk_answer,
  input  logic [NUM_WORKERS-1:0]    wk_found,
  input  logic [NUM_WORKERS-1:0]    wk_done,
  output logic [31:0]               answer,
  output logic                      found,
  output logic                      done,
  output logic                      busy
`ifdef CRACK_SCHED_PROGRESS_EN
  ,
  output logic [23:0]               chunks_issued
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Low CHUNK_DIGITS digits set to 9: OR-ing this into a chunk base gives the
  // last password of that chunk.
  function automatic logic [31:0] low_nines();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < CHUNK_DIGITS) m[4*i +: 4] = 4'h9;
    end
    return m;
  endfunction

  localparam logic [31:0] LOW_NINES = low_nines();

  // BCD increment of the digits above the chunk digits; bit 32 is the carry
  // out of digit 7.
  function automatic logic [32:0] bcd_advance(input logic [31:0] v);
    logic [31:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i >= CHUNK_DIGITS && carry) begin
        if (r[4*i +: 4] == 4'h9) begin
          r[4*i +: 4] = 4'h0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'h1;
          carry       = 1'b0;
        end
      end
    end
    return {carry, r};
  endfunction

  state_t                            state_q, state_d;
  logic [127:0]                      wk_hash_q, wk_hash_d;
  logic [NUM_WORKERS-1:0]            wk_rst_n_q, wk_rst_n_d;
  logic [32*NUM_WORKERS-1:0]         wk_lower_q, wk_lower_d;
  logic [32*NUM_WORKERS-1:0]         wk_upper_q, wk_upper_d;
  logic [31:0]                       answer_q, answer_d;
  logic                              found_q, found_d;
  logic                              done_q, done_d;
  logic                              busy_q, busy_d;
  logic [31:0]                       next_lo_q, next_lo_d;
  logic                              exhausted_q, exhausted_d;
  logic [NUM_WORKERS-1:0]            assigned_q, assigned_d;
  logic [NUM_WORKERS-1:0][1:0]       holdoff_q, holdoff_d;
`ifdef CRACK_SCHED_PROGRESS_EN
  logic [23:0]                       chunks_q, chunks_d;
`endif

  logic                              hit_any;
  logic [31:0]                       hit_answer;
  logic                              elig_any;
  logic [NUM_WORKERS-1:0]            elig_sel;
  logic                              drained;
  logic [32:0]                       adv;
  logic [31:0]                       chunk_top;
  logic [31:0]                       chunk_hi;

  always_comb begin
    state_d     = state_q;
    wk_hash_d   = wk_hash_q;
    wk_rst_n_d  = wk_rst_n_q;
    wk_lower_d  = wk_lower_q;
    wk_upper_d  = wk_upper_q;
    answer_d    = answer_q;
    found_d     = found_q;
    done_d      = done_q;
    busy_d      = busy_q;
    next_lo_d   = next_lo_q;
    exhausted_d = exhausted_q;
    assigned_d  = assigned_q;
    holdoff_d   = holdoff_q;
`ifdef CRACK_SCHED_PROGRESS_EN
    chunks_d    = chunks_q;
`endif
    hit_any     = 1'b0;
    hit_answer  = '0;
    elig_any    = 1'b0;
    elig_sel    = '0;
    drained     = 1'b1;

    adv       = bcd_advance(next_lo_q);
    chunk_top = next_lo_q | LOW_NINES;
    chunk_hi  = (chunk_top > END_BCD) ? END_BCD : chunk_top;

    for (int k = 0; k < NUM_WORKERS; k++) begin
      if (holdoff_q[k] != 2'd0) holdoff_d[k] = holdoff_q[k] - 2'd1;

      // Lowest index wins for both the hit and the next assignment.
      if (!hit_any && holdoff_q[k] == 2'd0 && wk_done[k] && wk_found[k]) begin
        hit_any    = 1'b1;
        hit_answer = wk_answer[32*k +: 32];
      end
      if (!elig_any && holdoff_q[k] == 2'd0 &&
          (!assigned_q[k] || (wk_done[k] && !wk_found[k]))) begin
        elig_any    = 1'b1;
        elig_sel[k] = 1'b1;
      end
      if (assigned_q[k] && !(wk_done[k] && holdoff_q[k] == 2'd0)) drained = 1'b0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        wk_rst_n_d = '0;
        if (start) begin
          state_d     = S_RUN;
          wk_hash_d   = hash_answer;
          next_lo_d   = '0;
          exhausted_d = 1'b0;
          assigned_d  = '0;
          holdoff_d   = '0;
          answer_d    = '0;
          found_d     = 1'b0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
`ifdef CRACK_SCHED_PROGRESS_EN
          chunks_d    = '0;
`endif
        end
      end

      S_RUN, S_DRAIN: begin
        // Assigned workers run; unassigned ones stay in reset.
        wk_rst_n_d = assigned_q;
        if (hit_any) begin
          state_d    = S_DONE;
          answer_d   = hit_answer;
          found_d    = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          wk_rst_n_d = '0;
        end else if (state_q == S_RUN) begin
          if (elig_any && !exhausted_q) begin
            for (int k = 0; k < NUM_WORKERS; k++) begin
              if (elig_sel[k]) begin
                wk_lower_d[32*k +: 32] = next_lo_q;
                wk_upper_d[32*k +: 32] = chunk_hi;
                wk_rst_n_d[k]          = 1'b0;
                holdoff_d[k]           = 2'd2;
                assigned_d[k]          = 1'b1;
              end
            end
`ifdef CRACK_SCHED_PROGRESS_EN
            if (chunks_q != '1) chunks_d = chunks_q + 24'd1;
`endif
            // next_lo is left untouched on exhaustion so it can never wrap.
            if (adv[32] || adv[31:0] > END_BCD) begin
              exhausted_d = 1'b1;
              state_d     = S_DRAIN;
            end else begin
              next_lo_d = adv[31:0];
            end
          end
        end else if (drained) begin
          state_d    = S_DONE;
          answer_d   = '0;
          found_d    = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          wk_rst_n_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wk_hash_q   <= '0;
      wk_rst_n_q  <= '0;
      wk_lower_q  <= '0;
      wk_upper_q  <= '0;
      answer_q    <= '0;
      found_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      next_lo_q   <= '0;
      exhausted_q <= 1'b0;
      assigned_q  <= '0;
      holdoff_q   <= '0;
`ifdef CRACK_SCHED_PROGRESS_EN
      chunks_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wk_hash_q   <= wk_hash_d;
      wk_rst_n_q  <= wk_rst_n_d;
      wk_lower_q  <= wk_lower_d;
      wk_upper_q  <= wk_upper_d;
      answer_q    <= answer_d;
      found_q     <= found_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      next_lo_q   <= next_lo_d;
      exhausted_q <= exhausted_d;
      assigned_q  <= assigned_d;
      holdoff_q   <= holdoff_d;
`ifdef CRACK_SCHED_PROGRESS_EN
      chunks_q    <= chunks_d;
`endif
    end
  end

  assign wk_hash  = wk_hash_q;
  assign wk_rst_n = wk_rst_n_q;
  assign wk_lower = wk_lower_q;
  assign wk_upper = wk_upper_q;
  assign answer   = answer_q;
  assign found    = found_q;
  assign done     = done_q;
  assign busy     = busy_q;
`ifdef CRACK_SCHED_PROGRESS_EN
  assign chunks_issued = chunks_q;
`endif

endmodule
